wb_mem_arbiter: RTL

Two-master, one-slave Wishbone (pipelined) arbiter that shares a single unified memory port between the instruction-fetch master and the memory-stage data master. It sits between the core's two bus masters and the memory. Data requests win by default, and a streak counter prevents fetch starvation. Each grant allows one outstanding transaction, guarded by a timeout so a dead slave cannot hang the pipeline.

---
 rtl/wb_mem_arbiter_if.sv | 48 ++++
 rtl/wb_mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter_if.sv
// rtl/wb_mem_arbiter_if.sv - Wishbone bundle for the fetch, data and memory ports of wb_mem_arbiter
// The slave modport is the arbiter's view; master is the view of the surrounding masters and memory.
interface wb_mem_arbiter_if;
  logic        i_wb_cyc_inst;
  logic        i_wb_stb_inst;
  logic [31:0] i_wb_addr_inst;
  logic        o_wb_ack_inst;
  logic        o_wb_stall_inst;
  logic [31:0] o_wb_data_inst;

  logic        i_wb_cyc_data;
  logic        i_wb_stb_data;
  logic        i_wb_we_data;
  logic [31:0] i_wb_addr_data;
  logic [31:0] i_wb_data_data;
  logic [3:0]  i_wb_sel_data;
  logic        o_wb_ack_data;
  logic        o_wb_stall_data;
  logic [31:0] o_wb_data_data;

  logic        o_wb_cyc_mem;
  logic        o_wb_stb_mem;
  logic        o_wb_we_mem;
  logic [31:0] o_wb_addr_mem;
  logic [31:0] o_wb_data_mem;
  logic [3:0]  o_wb_sel_mem;
  logic        i_wb_ack_mem;
  logic        i_wb_stall_mem;
  logic [31:0] i_wb_data_mem;

  modport slave (
    input  i_wb_cyc_inst, i_wb_stb_inst, i_wb_addr_inst,
    output o_wb_ack_inst, o_wb_stall_inst, o_wb_data_inst,
    input  i_wb_cyc_data, i_wb_stb_data, i_wb_we_data, i_wb_addr_data, i_wb_data_data, i_wb_sel_data,
    output o_wb_ack_data, o_wb_stall_data, o_wb_data_data,
    output o_wb_cyc_mem, o_wb_stb_mem, o_wb_we_mem, o_wb_addr_mem, o_wb_data_mem, o_wb_sel_mem,
    input  i_wb_ack_mem, i_wb_stall_mem, i_wb_data_mem
  );

  modport master (
    output i_wb_cyc_inst, i_wb_stb_inst, i_wb_addr_inst,
    input  o_wb_ack_inst, o_wb_stall_inst, o_wb_data_inst,
    output i_wb_cyc_data, i_wb_stb_data, i_wb_we_data, i_wb_addr_data, i_wb_data_data, i_wb_sel_data,
    input  o_wb_ack_data, o_wb_stall_data, o_wb_data_data,
    input  o_wb_cyc_mem, o_wb_stb_mem, o_wb_we_mem, o_wb_addr_mem, o_wb_data_mem, o_wb_sel_mem,
    output i_wb_ack_mem, i_wb_stall_mem, i_wb_data_mem
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - two-master pipelined Wishbone arbiter onto one memory port
// Data has priority; a streak counter lets a waiting fetch in; one outstanding access with timeout.
module wb_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  wb_mem_arbiter_if.slave  bus,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] LP_TO  = 8'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner_data;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic        r_we;
  logic [3:0]  r_streak;
  logic [7:0]  r_cnt;
  logic        r_timeout;

  logic w_req_inst;
  logic w_req_data;
  logic w_pick_data;
  logic w_pick_inst;
  logic w_owner_cyc;
  logic w_accept;
  logic w_ack_fwd;
  logic w_tmo;
  logic w_busy;

  assign w_req_inst  = bus.i_wb_cyc_inst & bus.i_wb_stb_inst;
  assign w_req_data  = bus.i_wb_cyc_data & bus.i_wb_stb_data;
  // Data loses only when it has used up its streak and a fetch is actually waiting.
  assign w_pick_data = w_req_data & ~((r_streak == LP_MAX) & w_req_inst);
  assign w_pick_inst = ~w_pick_data & w_req_inst;
  assign w_owner_cyc = r_owner_data ? bus.i_wb_cyc_data : bus.i_wb_cyc_inst;
  assign w_busy      = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack_fwd   = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_data || w_pick_inst) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!w_owner_cyc) begin
          w_state_nxt = S_IDLE;
        end else if (!bus.i_wb_stall_mem) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Owner abort beats a real ack, which in turn beats the timeout.
        if (!w_owner_cyc) begin
          w_state_nxt = S_IDLE;
        end else if (bus.i_wb_ack_mem) begin
          w_ack_fwd   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == LP_TO) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner_data <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sel        <= '0;
      r_we         <= 1'b0;
      r_streak     <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_pick_data) begin
        r_owner_data <= 1'b1;
        r_addr       <= bus.i_wb_addr_data;
        r_wdata      <= bus.i_wb_data_data;
        r_sel        <= bus.i_wb_sel_data;
        r_we         <= bus.i_wb_we_data;
        if (!w_req_inst) begin
          r_streak <= '0;
        end else if (r_streak != 4'hF) begin
          r_streak <= r_streak + 4'd1;
        end
      end else if (w_pick_inst) begin
        r_owner_data <= 1'b0;
        r_addr       <= bus.i_wb_addr_inst;
        r_wdata      <= '0;
        r_sel        <= 4'hF;
        r_we         <= 1'b0;
        r_streak     <= '0;
      end
    end
  end

  // The counter free-runs outside IDLE; only the WAIT value matters for the timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_accept || r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;

  assign bus.o_wb_cyc_mem  = w_busy;
  assign bus.o_wb_stb_mem  = (r_state == S_ISSUE);
  assign bus.o_wb_we_mem   = w_busy & r_we;
  assign bus.o_wb_addr_mem = w_busy ? r_addr  : 32'h0;
  assign bus.o_wb_data_mem = w_busy ? r_wdata : 32'h0;
  assign bus.o_wb_sel_mem  = w_busy ? r_sel   : 4'h0;

  // Only the IDLE winner sees stall low, and never while reset is held.
  assign bus.o_wb_stall_data = i_rst | ~((r_state == S_IDLE) & w_pick_data);
  assign bus.o_wb_stall_inst = i_rst | ~((r_state == S_IDLE) & w_pick_inst);

  assign bus.o_wb_ack_data  = (w_ack_fwd | w_tmo) & r_owner_data;
  assign bus.o_wb_ack_inst  = (w_ack_fwd | w_tmo) & ~r_owner_data;
  assign bus.o_wb_data_data = (w_ack_fwd & r_owner_data)  ? bus.i_wb_data_mem : 32'h0;
  assign bus.o_wb_data_inst = (w_ack_fwd & ~r_owner_data) ? bus.i_wb_data_mem : 32'h0;

endmodule
